trig_arbiter: RTL and testbench

TRIG_ARBITER -- requirements
Module: trig_arbiter

---
 rtl/trig_arbiter_pkg.sv | 19 +
 rtl/trig_arbiter_if.sv | 30 +++
 rtl/trig_arbiter_rr_arbiter.sv | 30 +++
 rtl/trig_arbiter.sv | 178 +++++++++++++++++
 tb/tb_trig_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/trig_arbiter_pkg.sv
// Shared constants and FSM state type for the trig_arbiter cos/sin request arbiter.
package clbp_pkg;
    localparam int INT_W  = 9;
    localparam int FRAC_W = 16;
    localparam int FIX_W  = INT_W + FRAC_W;
    localparam int N_REQ  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Index width that stays legal even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/trig_arbiter_if.sv
// Requester- and responder-side handshake bundle of the trig_arbiter.
interface trig_arbiter_if #(
    parameter int N_REQ = clbp_pkg::N_REQ,
    parameter int FIX_W = clbp_pkg::FIX_W
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*FIX_W-1:0] req_theta;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [FIX_W-1:0]       rsp_cos;
    logic [FIX_W-1:0]       rsp_sin;
    logic                   rsp_err;
    logic [FIX_W-1:0]       theta;
    logic                   theta_valid;
    logic [FIX_W-1:0]       cos_data;
    logic [FIX_W-1:0]       sin_data;
    logic                   cos_valid;
    logic                   sin_valid;

    // The arbiter is the slave of this bundle; requesters and responder form the master side.
    modport slave (
        input  req_valid, req_theta, cos_data, sin_data, cos_valid, sin_valid,
        output req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_err, theta, theta_valid
    );

    modport master (
        output req_valid, req_theta, cos_data, sin_data, cos_valid, sin_valid,
        input  req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_err, theta, theta_valid
    );
endinterface

// File: rtl/trig_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first pending requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int N_REQ = clbp_pkg::N_REQ,
    parameter int IDX_W = clbp_pkg::idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);
    import clbp_pkg::*;

    logic found;
    int   cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_i) + k) % N_REQ;
            if (!found && req_i[IDX_W'(cand)]) begin
                found                = 1'b1;
                gnt_o[IDX_W'(cand)]  = 1'b1;
                gnt_idx_o            = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/trig_arbiter.sv
// Round-robin arbiter sharing one cos/sin responder among N_REQ requesters.
// One transaction at a time (IDLE -> ISSUE -> WAIT -> RESP); every output is a flop.
module trig_arbiter #(
    parameter int N_REQ   = clbp_pkg::N_REQ,
    parameter int FIX_W   = clbp_pkg::FIX_W,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    trig_arbiter_if.slave bus
);
    import clbp_pkg::*;

    localparam int IDX_W = idx_width(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             cos_got_q, cos_got_d;
    logic             sin_got_q, sin_got_d;
    logic [FIX_W-1:0] cos_w_q, cos_w_d;
    logic [FIX_W-1:0] sin_w_q, sin_w_d;

    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic [FIX_W-1:0] theta_q, theta_d;
    logic             theta_valid_q, theta_valid_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [FIX_W-1:0] rsp_cos_q, rsp_cos_d;
    logic [FIX_W-1:0] rsp_sin_q, rsp_sin_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic [FIX_W-1:0] theta_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign theta_arr[i] = bus.req_theta[i*FIX_W +: FIX_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i     (bus.req_valid),
        .last_i    (last_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        last_d        = last_q;
        gidx_d        = gidx_q;
        gnt_d         = gnt_q;
        cos_got_d     = cos_got_q;
        sin_got_d     = sin_got_q;
        cos_w_d       = cos_w_q;
        sin_w_d       = sin_w_q;
        req_ready_d   = '0;
        theta_d       = '0;
        theta_valid_d = 1'b0;
        rsp_valid_d   = '0;
        rsp_cos_d     = '0;
        rsp_sin_d     = '0;
        rsp_err_d     = 1'b0;

        // Output flops load the values of the state being entered.
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    state_d       = ST_ISSUE;
                    gidx_d        = arb_idx;
                    gnt_d         = arb_gnt;
                    req_ready_d   = arb_gnt;
                    theta_valid_d = 1'b1;
                    theta_d       = theta_arr[arb_idx];
                end
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT;
                timer_d   = '0;
                cos_got_d = 1'b0;
                sin_got_d = 1'b0;
            end
            ST_WAIT: begin
                if (bus.cos_valid) begin
                    cos_got_d = 1'b1;
                    cos_w_d   = bus.cos_data;
                end
                if (bus.sin_valid) begin
                    sin_got_d = 1'b1;
                    sin_w_d   = bus.sin_data;
                end
                if (cos_got_d && sin_got_d) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = gnt_q;
                    rsp_cos_d   = cos_w_d;
                    rsp_sin_d   = sin_w_d;
                end else if (timer_q == TMR_LAST) begin
                    // Timeout: report what arrived, zero what did not.
                    state_d     = ST_RESP;
                    rsp_valid_d = gnt_q;
                    rsp_err_d   = 1'b1;
                    rsp_cos_d   = cos_got_d ? cos_w_d : '0;
                    rsp_sin_d   = sin_got_d ? sin_w_d : '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                last_d  = gidx_q;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            last_q        <= LAST_RST;
            gidx_q        <= '0;
            gnt_q         <= '0;
            cos_got_q     <= 1'b0;
            sin_got_q     <= 1'b0;
            req_ready_q   <= '0;
            theta_q       <= '0;
            theta_valid_q <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_cos_q     <= '0;
            rsp_sin_q     <= '0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            last_q        <= last_d;
            gidx_q        <= gidx_d;
            gnt_q         <= gnt_d;
            cos_got_q     <= cos_got_d;
            sin_got_q     <= sin_got_d;
            req_ready_q   <= req_ready_d;
            theta_q       <= theta_d;
            theta_valid_q <= theta_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_cos_q     <= rsp_cos_d;
            rsp_sin_q     <= rsp_sin_d;
            rsp_err_q     <= rsp_err_d;
            busy_q        <= busy_d;
        end
    end

    // Captured words are qualified by the got flags, so they need no reset.
    always_ff @(posedge clk) begin
        cos_w_q <= cos_w_d;
        sin_w_q <= sin_w_d;
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.theta       = theta_q;
    assign bus.theta_valid = theta_valid_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_cos     = rsp_cos_q;
    assign bus.rsp_sin     = rsp_sin_q;
    assign bus.rsp_err     = rsp_err_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_trig_arbiter.sv
// Self-checking bench for trig_arbiter: transaction-level reference model plus a
// latency-programmable responder that also injects stray valids outside WAIT.
module tb_trig_arbiter;
    localparam int NR = 4;
    localparam int FW = 25;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    trig_arbiter_if #(.N_REQ(NR), .FIX_W(FW)) bus ();

    trig_arbiter #(
        .N_REQ   (NR),
        .FIX_W   (FW),
        .TIMEOUT (TO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .busy (busy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int last_g  = NR - 1;

    // Responder programme for the transaction in flight (latency 0 = never answers).
    int            cur_cl = 0;
    int            cur_sl = 0;
    int            cur_w  = 0;
    logic [FW-1:0] cur_cv = '0;
    logic [FW-1:0] cur_sv = '0;
    logic [FW-1:0] th [NR];

    function automatic logic [127:0] pk(input logic [NR-1:0] rr, input logic tv,
                                        input logic [FW-1:0] t, input logic [NR-1:0] rv,
                                        input logic [FW-1:0] rc, input logic [FW-1:0] rs,
                                        input logic re, input logic b);
        return 128'({rr, tv, t, rv, rc, rs, re, b});
    endfunction

    function automatic logic [127:0] obs();
        return pk(bus.req_ready, bus.theta_valid, bus.theta, bus.rsp_valid,
                  bus.rsp_cos, bus.rsp_sin, bus.rsp_err, busy);
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] m, input int last);
        for (int k = 1; k <= NR; k++) begin
            int j = (last + k) % NR;
            if (m[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction, checked every cycle from ISSUE through the following IDLE.
    task automatic run_txn(input string tag, input logic [NR-1:0] mask, input int cl,
                           input int sl, input logic [FW-1:0] cv, input logic [FW-1:0] sv,
                           input bit scr);
        int g;
        int w;
        bit cap_c, cap_s, err;
        logic [FW-1:0] exp_th;
        g      = rr_pick(mask, last_g);
        cap_c  = (cl >= 1) && (cl <= TO);
        cap_s  = (sl >= 1) && (sl <= TO);
        err    = !(cap_c && cap_s);
        w      = err ? TO : ((cl > sl) ? cl : sl);
        cur_cl = cl;
        cur_sl = sl;
        cur_w  = w;
        cur_cv = cv;
        cur_sv = sv;
        bus.req_theta = {th[3], th[2], th[1], th[0]};
        bus.req_valid = mask;
        exp_th = th[g[1:0]];
        cyc();
        chk({tag, " issue"}, obs(), pk(NR'(1 << g), 1'b1, exp_th, '0, '0, '0, 1'b0, 1'b1));
        if (scr) begin
            for (int i = 0; i < NR; i++) th[i] = FW'($urandom);
            bus.req_theta = {th[3], th[2], th[1], th[0]};
            bus.req_valid = NR'($urandom);
        end
        for (int i = 0; i < w; i++) begin
            cyc();
            chk({tag, " wait"}, obs(), pk('0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1));
        end
        cyc();
        chk({tag, " resp"}, obs(), pk('0, 1'b0, '0, NR'(1 << g), cap_c ? cv : '0,
                                      cap_s ? sv : '0, err, 1'b1));
        last_g = g;
        if (scr) bus.req_valid = '0;
        cyc();
        chk({tag, " idle"}, obs(), '0);
    endtask

    // Responder: valid lands in WAIT cycle N for latency N; random strays once WAIT is over.
    initial begin
        int   wc;
        logic iss;
        bit   hit_c, hit_s;
        wc = 0;
        bus.cos_valid = 1'b0;
        bus.sin_valid = 1'b0;
        bus.cos_data  = '0;
        bus.sin_data  = '0;
        forever begin
            @(negedge clk);
            iss = bus.theta_valid;
            @(posedge clk);
            #1;
            if (iss === 1'b1) wc = 1;
            else if (wc > 0 && wc < 1000) wc++;
            hit_c = (cur_cl > 0) && (wc == cur_cl);
            hit_s = (cur_sl > 0) && (wc == cur_sl);
            bus.cos_valid = hit_c || (wc > cur_w && $urandom_range(0, 1) == 1);
            bus.sin_valid = hit_s || (wc > cur_w && $urandom_range(0, 1) == 1);
            bus.cos_data  = hit_c ? cur_cv : FW'($urandom);
            bus.sin_data  = hit_s ? cur_sv : FW'($urandom);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, cl, sl;
        bus.req_valid = '0;
        bus.req_theta = '0;
        for (int i = 0; i < NR; i++) th[i] = '0;
        #1;
        chk("reset outputs", obs(), '0);
        cyc();
        cyc();
        chk("reset held", obs(), '0);
        rst = 1'b1;

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NR; i++) th[i] = FW'($urandom);
            run_txn("all4", 4'b1111, 1, 1, FW'($urandom), FW'($urandom), 1'b0);
        end

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NR; i++) th[i] = FW'($urandom);
            run_txn("req0+2", 4'b0101, 1, 1, FW'($urandom), FW'($urandom), 1'b0);
        end

        th[0] = 25'h0010000;
        run_txn("single", 4'b0001, 1, 1, 25'h0008A51, 25'h000D76A, 1'b1);
        th[1] = 25'h1FF0000;
        run_txn("cos1-sin3", 4'b0010, 1, 3, 25'h0001234, 25'h1FEDCBA, 1'b1);
        th[3] = 25'h0004000;
        run_txn("silent", 4'b1000, 0, 0, FW'($urandom), FW'($urandom), 1'b1);
        th[3] = 25'h0008000;
        run_txn("after-timeout", 4'b1000, 1, 1, 25'h0000ABC, 25'h0000DEF, 1'b1);
        run_txn("cos-only", 4'b0001, 5, 0, 25'h0123456, FW'($urandom), 1'b1);
        run_txn("sin-late", 4'b0001, 2, TO + 2, 25'h0000777, 25'h0000888, 1'b1);
        run_txn("last-wait-cycle", 4'b0100, TO, TO, 25'h1000001, 25'h0FFFFFF, 1'b1);
        run_txn("one-cycle-late", 4'b0100, TO, TO + 1, 25'h0000055, 25'h00000AA, 1'b1);
        for (int i = 0; i < NR; i++) th[i] = '0;
        run_txn("theta-zero", 4'b0010, 2, 2, 25'h0010000, 25'h0000000, 1'b1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR; i++) th[i] = FW'($urandom);
            r  = $urandom_range(0, 9);
            cl = (r == 0) ? 0 : (r == 1) ? TO + $urandom_range(1, 3) : $urandom_range(1, 6);
            r  = $urandom_range(0, 9);
            sl = (r == 0) ? 0 : (r == 1) ? TO + $urandom_range(1, 3) : $urandom_range(1, 6);
            run_txn("random", NR'($urandom_range(1, 15)), cl, sl, FW'($urandom),
                    FW'($urandom), 1'b1);
        end

        // Reset while the transaction sits in WAIT.
        for (int i = 0; i < NR; i++) th[i] = FW'($urandom);
        cur_cl = 3;
        cur_sl = 3;
        cur_w  = 3;
        bus.req_theta = {th[3], th[2], th[1], th[0]};
        bus.req_valid = 4'b0100;
        cyc();
        chk("pre-reset issue", obs(), pk(4'b0100, 1'b1, th[2], '0, '0, '0, 1'b0, 1'b1));
        bus.req_valid = '0;
        cyc();
        chk("pre-reset wait", obs(), pk('0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1));
        rst = 1'b0;
        #1;
        chk("async reset", obs(), '0);
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 3; n++) begin
            cyc();
            chk("in reset", obs(), '0);
        end
        rst    = 1'b1;
        last_g = NR - 1;
        run_txn("post-reset", 4'b1111, 1, 1, FW'($urandom), FW'($urandom), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
